// File: rtl/crc10_checker.sv
// crc10_checker
//   Receive-side CRC-10 checker. Absorbs a frame of 32-bit data words, one
//   whole word per accepted beat, recomputes CRC-10 (poly 0x233, init 0,
//   no final XOR, word bit 0 first) and compares it with the CRC beat that
//   follows the last data word. Reports a one-cycle result per frame and
//   keeps a saturating count of failed frames.
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous active-low reset
//     s_valid   input beat valid
//     s_ready   checker can accept a beat (registered)
//     s_data    data word; on the CRC beat the CRC sits in [9:0]
//     s_last    marks the last DATA word of a frame
//     clr_cnt   synchronous clear of err_cnt (wins over an increment)
//     chk_done  one-cycle pulse, frame result valid
//     chk_ok    received CRC matched the computed CRC
//     len_err   frame reached MAX_WORDS without s_last
//     crc_calc  computed CRC of the last checked frame
//     crc_rx    received CRC of the last checked frame
//     err_cnt   saturating failed-frame count
module crc10_checker #(
   parameter int MAX_WORDS = 64,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   input  logic             s_last,
   input  logic             clr_cnt,
   output logic             chk_done,
   output logic             chk_ok,
   output logic             len_err,
   output logic [9:0]       crc_calc,
   output logic [9:0]       crc_rx,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int               WC_W    = $clog2(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CHECK   = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [9:0]        acc_r;
   logic [WC_W-1:0]   word_cnt_r;
   logic              len_err_pend_r;
   logic              s_ready_r;
   logic              chk_done_r;
   logic              chk_ok_r;
   logic              len_err_r;
   logic [9:0]        crc_calc_r;
   logic [9:0]        crc_rx_r;
   logic [CNT_W-1:0]  err_cnt_r;
   logic              accept_s;
   logic              last_slot_s;
   logic              ok_s;

   // Absorb one 32-bit word into the CRC, bit 0 first (32 serial steps unrolled).
   function automatic logic [9:0] crc32_step(input logic [9:0] acc, input logic [31:0] din);
      logic [9:0] c;
      logic       fb;
      c = acc;
      for (int i = 0; i < 32; i++) begin
         fb = c[9] ^ din[i];
         c  = {c[8:0], 1'b0} ^ (fb ? 10'h233 : 10'h000);
      end
      return c;
   endfunction

   // Beat acceptance and per-beat decisions.
   always_comb begin
      accept_s    = s_valid && s_ready_r;
      // word_cnt counts words already absorbed, so this beat fills the last slot
      last_slot_s = (word_cnt_r == WC_W'(MAX_WORDS - 1));
      ok_s        = (s_data[9:0] == acc_r) && (s_data[31:10] == 22'd0) && !len_err_pend_r;
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         COLLECT: begin
            if (accept_s && (s_last || last_slot_s)) begin
               state_s = CHECK;
            end else begin
               state_s = COLLECT;
            end
         end
         CHECK: begin
            if (accept_s) begin
               state_s = REPORT;
            end else begin
               state_s = CHECK;
            end
         end
         REPORT:  state_s = COLLECT;
         default: state_s = COLLECT;
      endcase
   end

   // State register plus registered ready/done, both derived from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= COLLECT;
         s_ready_r  <= 1'b0;
         chk_done_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         s_ready_r  <= (state_s != REPORT);
         chk_done_r <= (state_s == REPORT);
      end
   end

   // Frame datapath: CRC accumulation, word count and captured results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r          <= 10'd0;
         word_cnt_r     <= '0;
         len_err_pend_r <= 1'b0;
         chk_ok_r       <= 1'b0;
         len_err_r      <= 1'b0;
         crc_calc_r     <= 10'd0;
         crc_rx_r       <= 10'd0;
      end else begin
         case (state_r)
            COLLECT: begin
               if (accept_s) begin
                  acc_r      <= crc32_step(acc_r, s_data);
                  word_cnt_r <= word_cnt_r + WC_W'(1);
                  if (!s_last && last_slot_s) begin
                     len_err_pend_r <= 1'b1;
                  end
               end
            end
            CHECK: begin
               // s_last is deliberately ignored on the CRC beat
               if (accept_s) begin
                  crc_rx_r   <= s_data[9:0];
                  crc_calc_r <= acc_r;
                  chk_ok_r   <= ok_s;
                  len_err_r  <= len_err_pend_r;
               end
            end
            REPORT: begin
               acc_r          <= 10'd0;
               word_cnt_r     <= '0;
               len_err_pend_r <= 1'b0;
            end
            default: begin
               acc_r          <= 10'd0;
               word_cnt_r     <= '0;
               len_err_pend_r <= 1'b0;
            end
         endcase
      end
   end

   // Saturating failed-frame counter; clear has priority over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt_r <= '0;
      end else if (clr_cnt) begin
         err_cnt_r <= '0;
      end else if ((state_r == REPORT) && !chk_ok_r && (err_cnt_r != CNT_MAX)) begin
         err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
   end

   assign s_ready  = s_ready_r;
   assign chk_done = chk_done_r;
   assign chk_ok   = chk_ok_r;
   assign len_err  = len_err_r;
   assign crc_calc = crc_calc_r;
   assign crc_rx   = crc_rx_r;
   assign err_cnt  = err_cnt_r;

endmodule
